// File: rtl/display_value_scheduler_if.sv
// Display scheduler bus: source values/valids and advance controls in, BCD digits and status out.
// The master side drives the sources; the slave side is the scheduler.
interface display_value_scheduler_if #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
);
    logic [NUM_SRC-1:0]    src_valid;
    logic [32*NUM_SRC-1:0] src_vals;
    logic                  next_btn;
    logic                  hold;
    logic [SEL_W-1:0]      sel_idx;
    logic [19:0]           bcd_digits;
    logic                  is_negative;
    logic                  overflow;
    logic                  busy;
    logic                  update_pulse;

    modport master (
        output src_valid, src_vals, next_btn, hold,
        input  sel_idx, bcd_digits, is_negative, overflow, busy, update_pulse
    );

    modport slave (
        input  src_valid, src_vals, next_btn, hold,
        output sel_idx, bcd_digits, is_negative, overflow, busy, update_pulse
    );
endinterface

// File: rtl/display_value_scheduler.sv
// Round-robin display source picker with signed binary-to-BCD conversion; 19 cycles LATCH->outputs (2 on overflow).
// No backpressure: sources are sampled once per refresh and advance requests collapse into a single pending flag.
module display_value_scheduler #(
    parameter int NUM_SRC      = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int SEL_W        = 2
) (
    input logic                    clk,
    input logic                    rst_n,
    display_value_scheduler_if.slave bus
);

    localparam int              CNT_W      = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LATCH, CONVERT, COMMIT} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             pend_q, pend_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic [16:0]      shift_q, shift_d;
    logic [19:0]      acc_q, acc_d;
    logic [4:0]       bit_q, bit_d;
    logic [19:0]      digits_q, digits_d;
    logic             is_neg_q, is_neg_d;
    logic             ovf_out_q, ovf_out_d;
    logic             busy_q, busy_d;
    logic             upd_q, upd_d;

    logic [31:0]      vals [NUM_SRC];
    logic [SEL_W-1:0] nxt_sel;
    logic [SEL_W-1:0] cand;
    logic             found;
    logic             any_vld;
    logic             adv_req;
    logic [31:0]      v;
    logic [31:0]      mag;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign vals[g] = bus.src_vals[32*g +: 32];
    end

    function automatic logic [19:0] add3(input logic [19:0] b);
        logic [19:0] r;
        r = b;
        for (int n = 0; n < 5; n++) begin
            if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Search starts just past the current index so the current one is the last candidate.
    always_comb begin
        nxt_sel = sel_q;
        cand    = sel_q;
        found   = 1'b0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = SEL_W'((int'(sel_q) + i) % NUM_SRC);
            if (!found && bus.src_valid[cand]) begin
                found   = 1'b1;
                nxt_sel = cand;
            end
        end
    end

    assign any_vld = |bus.src_valid;
    assign adv_req = bus.next_btn | (!bus.hold && (dwell_q == DWELL_LAST));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        shift_d   = shift_q;
        acc_d     = acc_q;
        bit_d     = bit_q;
        digits_d  = digits_q;
        is_neg_d  = is_neg_q;
        ovf_out_d = ovf_out_q;
        upd_d     = 1'b0;
        pend_d    = pend_q | adv_req;
        v         = vals[sel_q];
        mag       = v[31] ? (~v + 32'd1) : v;

        case (state_q)
            IDLE: begin
                if (any_vld) begin
                    if (pend_q || adv_req || !bus.src_valid[sel_q]) sel_d = nxt_sel;
                    pend_d  = 1'b0;
                    state_d = LATCH;
                end
            end
            LATCH: begin
                neg_d   = v[31];
                ovf_d   = (mag > 32'd99999);
                shift_d = mag[16:0];
                acc_d   = '0;
                bit_d   = '0;
                state_d = (mag > 32'd99999) ? COMMIT : CONVERT;
            end
            CONVERT: begin
                {acc_d, shift_d} = {add3(acc_q), shift_q} << 1;
                bit_d = bit_q + 5'd1;
                if (bit_q == 5'd16) state_d = COMMIT;
            end
            COMMIT: begin
                digits_d  = ovf_q ? 20'h99999 : acc_q;
                is_neg_d  = neg_q;
                ovf_out_d = ovf_q;
                upd_d     = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A new source always gets a full dwell period.
        if (sel_d != sel_q)         dwell_d = '0;
        else if (bus.hold)          dwell_d = dwell_q;
        else if (dwell_q == DWELL_LAST) dwell_d = '0;
        else                        dwell_d = dwell_q + CNT_W'(1);

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            dwell_q   <= '0;
            pend_q    <= 1'b0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            shift_q   <= '0;
            acc_q     <= '0;
            bit_q     <= '0;
            digits_q  <= '0;
            is_neg_q  <= 1'b0;
            ovf_out_q <= 1'b0;
            busy_q    <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            dwell_q   <= dwell_d;
            pend_q    <= pend_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            shift_q   <= shift_d;
            acc_q     <= acc_d;
            bit_q     <= bit_d;
            digits_q  <= digits_d;
            is_neg_q  <= is_neg_d;
            ovf_out_q <= ovf_out_d;
            busy_q    <= busy_d;
            upd_q     <= upd_d;
        end
    end

    assign bus.sel_idx      = sel_q;
    assign bus.bcd_digits   = digits_q;
    assign bus.is_negative  = is_neg_q;
    assign bus.overflow     = ovf_out_q;
    assign bus.busy         = busy_q;
    assign bus.update_pulse = upd_q;

endmodule

// File: tb/tb_display_value_scheduler.sv
// Bench for display_value_scheduler: vector table plus hand sequences for rotation, collapsed advances,
// empty-valid idling and mid-conversion reset, with expected results queued and popped on update_pulse.
module tb_display_value_scheduler;

    logic clk;
    logic rst_n;

    display_value_scheduler_if #(.NUM_SRC(4), .SEL_W(2)) bus ();

    display_value_scheduler #(
        .NUM_SRC(4),
        .DWELL_CYCLES(64),
        .SEL_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
        int          sel;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] val;
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
        int          lat;
    } vec_t;

    localparam int NV = 11;

    exp_t        sb[$];
    exp_t        last;
    vec_t        vecs [NV];
    logic [31:0] srcv [4];
    int          n_pass = 0;
    int          n_chk  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_chk++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    endtask

    function automatic exp_t model(input logic [31:0] v, input int sel, input int lat);
        exp_t   e;
        longint m;
        e.neg = v[31];
        m     = v[31] ? (64'd4294967296 - longint'(v)) : longint'(v);
        e.ovf = (m > 99999);
        e.bcd = 20'h99999;
        if (!e.ovf) begin
            for (int d = 0; d < 5; d++) begin
                e.bcd[4*d +: 4] = 4'(m % 10);
                m = m / 10;
            end
        end
        e.sel = sel;
        e.lat = lat;
        return e;
    endfunction

    task automatic drive_srcs();
        bus.src_vals = {srcv[3], srcv[2], srcv[1], srcv[0]};
    endtask

    // Waits for the next update_pulse; latency counts from the first busy cycle seen to the pulse.
    task automatic expect_next(input string tag, input int budget);
        exp_t e;
        bit   got;
        int   lat;
        int   rise;
        got  = 1'b0;
        lat  = -1;
        rise = -1;
        e    = sb.pop_front();
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (bus.busy && rise < 0) rise = i;
            if (bus.update_pulse) begin
                got = 1'b1;
                lat = i - rise;
            end
        end
        check({tag, "_pulse_seen"}, got, 1);
        if (got) begin
            check({tag, "_sel"}, bus.sel_idx, e.sel);
            check({tag, "_bcd"}, bus.bcd_digits, e.bcd);
            check({tag, "_neg"}, bus.is_negative, e.neg);
            check({tag, "_ovf"}, bus.overflow, e.ovf);
            if (e.lat >= 0) check({tag, "_latency"}, lat, e.lat);
            last = e;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sel"}, bus.sel_idx, 0);
        check({tag, "_bcd"}, bus.bcd_digits, 0);
        check({tag, "_neg"}, bus.is_negative, 0);
        check({tag, "_ovf"}, bus.overflow, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_upd"}, bus.update_pulse, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   chg_sel [4];
        int   chg_cyc [4];
        int   t3_exp  [4];
        int   nchg;
        int   prev_sel;
        bit   prev_busy;
        int   s0;
        bit   seen;
        int   n_upd;
        int   n_busy;
        exp_t e;

        vecs[0]  = '{32'd12345,      20'h12345, 1'b0, 1'b0, 19};
        vecs[1]  = '{32'hFFFF_FF85,  20'h00123, 1'b1, 1'b0, 19};
        vecs[2]  = '{32'hFFFE_7960,  20'h99999, 1'b1, 1'b1, 2};
        vecs[3]  = '{32'h8000_0000,  20'h99999, 1'b1, 1'b1, 2};
        vecs[4]  = '{32'd99999,      20'h99999, 1'b0, 1'b0, 19};
        vecs[5]  = '{32'd0,          20'h00000, 1'b0, 1'b0, 19};
        vecs[6]  = '{32'd100000,     20'h99999, 1'b0, 1'b1, 2};
        vecs[7]  = '{32'hFFFF_FFFF,  20'h00001, 1'b1, 1'b0, 19};
        vecs[8]  = '{32'h7FFF_FFFF,  20'h99999, 1'b0, 1'b1, 2};
        vecs[9]  = '{32'd90817,      20'h90817, 1'b0, 1'b0, 19};
        vecs[10] = '{32'hFFFE_7961,  20'h99999, 1'b1, 1'b0, 19};
        t3_exp   = '{1, 3, 1, 3};

        rst_n         = 1'b0;
        bus.next_btn  = 1'b0;
        bus.hold      = 1'b1;
        bus.src_valid = 4'b1111;
        srcv          = '{vecs[0].val, 32'd1, 32'd2, 32'd3};
        drive_srcs();
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Table: each new value is driven in the cycle of the previous update_pulse, before LATCH.
        for (int i = 0; i < NV; i++) begin
            if (i > 0) begin
                srcv[0] = vecs[i].val;
                drive_srcs();
            end
            e.bcd = vecs[i].bcd;
            e.neg = vecs[i].neg;
            e.ovf = vecs[i].ovf;
            e.sel = 0;
            e.lat = vecs[i].lat;
            sb.push_back(e);
            expect_next($sformatf("vec%0d", i), 60);
        end

        // Back-to-back refresh of an unchanged source repeats the same result.
        sb.push_back(model(srcv[0], 0, 19));
        expect_next("refresh", 60);

        // A source change during CONVERT only shows on the following refresh.
        sb.push_back(model(srcv[0], 0, -1));
        sb.push_back(model(32'd4321, 0, 19));
        repeat (5) @(negedge clk);
        srcv[0] = 32'd4321;
        drive_srcs();
        expect_next("midchg_old", 60);
        expect_next("midchg_new", 60);

        // Dwell rotation over sources 1 and 3.
        srcv = '{32'd11111, 32'd22222, 32'hFFFF_F2FB, 32'd44444};
        drive_srcs();
        bus.src_valid = 4'b1010;
        bus.hold      = 1'b0;
        chg_sel   = '{-1, -1, -1, -1};
        chg_cyc   = '{0, 0, 0, 0};
        nchg      = 0;
        prev_sel  = int'(bus.sel_idx);
        prev_busy = bus.busy;
        for (int i = 0; i < 600 && nchg < 4; i++) begin
            @(negedge clk);
            if (int'(bus.sel_idx) != prev_sel) begin
                check("rot_idle_at_change", prev_busy, 0);
                chg_sel[nchg] = int'(bus.sel_idx);
                chg_cyc[nchg] = i;
                nchg++;
            end
            prev_sel  = int'(bus.sel_idx);
            prev_busy = bus.busy;
        end
        check("rot_change_count", nchg, 4);
        for (int k = 0; k < 4; k++) check($sformatf("rot_sel%0d", k), chg_sel[k], t3_exp[k]);
        for (int k = 1; k < 4; k++) check_range($sformatf("rot_dwell%0d", k), chg_cyc[k] - chg_cyc[k-1], 64, 84);

        // Button in the same cycle as dwell expiry, mid-CONVERT, yields one advance after COMMIT.
        bus.src_valid = 4'b1111;
        prev_sel = int'(bus.sel_idx);
        seen     = 1'b0;
        s0       = prev_sel;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (int'(bus.sel_idx) != prev_sel) begin
                seen = 1'b1;
                s0   = int'(bus.sel_idx);
            end
        end
        check("collapse_dwell_change", seen, 1);
        check("collapse_wrap_sel", s0, 0);
        repeat (63) @(negedge clk);
        bus.next_btn = 1'b1;
        @(negedge clk);
        bus.next_btn = 1'b0;
        sb.push_back(model(srcv[s0], s0, -1));
        expect_next("collapse_old", 40);
        sb.push_back(model(srcv[(s0 + 1) % 4], (s0 + 1) % 4, 19));
        expect_next("collapse_new", 40);

        // No valid source: idle with outputs held, then a lone valid source is picked up.
        bus.src_valid = 4'b0000;
        bus.hold      = 1'b1;
        n_upd  = 0;
        n_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.update_pulse) n_upd++;
            if (bus.busy) n_busy++;
        end
        check("novld_pulses", n_upd, 0);
        check("novld_busy", n_busy, 0);
        check("novld_bcd_held", bus.bcd_digits, last.bcd);
        check("novld_neg_held", bus.is_negative, last.neg);
        check("novld_sel_held", bus.sel_idx, last.sel);
        bus.src_valid = 4'b0100;
        sb.push_back(model(srcv[2], 2, 19));
        expect_next("single_vld", 60);

        // Reset asserted in the ninth CONVERT cycle clears everything immediately.
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(negedge clk);
        bus.src_valid = 4'b1111;
        rst_n = 1'b1;
        sb.push_back(model(srcv[0], 0, 19));
        expect_next("after_reset", 60);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
